vga_face_sequencer: RTL and testbench
=====================================

# vga_face_sequencer

Frame-synchronous controller that owns the `face_select` and filter-select configuration of the VGA face streamer. It arbitrates configuration requests from two requesters (push-button front end, audio classifier) and holds at most one accepted request pending. It commits the pending request only at an Avalon-ST frame boundary, so a displayed frame never mixes faces or filters. When idle, it optionally auto-cycles the face every `AUTO_FRAMES` frames.

## Interface
Parameters:
- `AUTO_FRAMES`, 60: frame boundaries between automatic face advances; legal range 1..65535.
- `CNT_W`, 16: width of the frame-boundary counter; must hold `AUTO_FRAMES-1`.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  streamer `valid` (monitored only).
- `st_ready`  in  1  sink `ready` (monitored only).
- `st_endofpacket`  in  1  streamer `endofpacket`.
- `btn_valid`  in  1  button requester has a request.
- `btn_data`  in  6  {face[1:0], filter[3:0]}.
- `btn_ready`  out  1  button request accepted this cycle when `btn_valid & btn_ready`.
- `aud_valid`  in  1  audio requester has a request.
- `aud_data`  in  6  {face[1:0], filter[3:0]}.
- `aud_ready`  out  1  audio request accepted when `aud_valid & aud_ready`.
- `auto_en`  in  1  enables auto-cycling.
- `face_select`  out  2  face to streamer: 0 wolf, 1 P2, 2 colour.
- `filter_select`  out  4  one-hot filter: 0000 none, 0001 invert, 0010 lighten, 0100 darken, 1000 grey.
- `pending`  out  1  a request is held awaiting a boundary.
- `commit`  out  1  one-cycle pulse: configuration changed.
- `req_err`  out  1  one-cycle pulse: accepted request was illegal and discarded.

## Operation
- Frame boundary (FB) = `st_valid & st_ready & st_endofpacket`, sampled each cycle.
- Arbitration:
  - `btn_ready = ~pending`.
  - `aud_ready = ~pending & ~btn_valid`. The button has fixed priority.
  - Both ready signals are combinational from registered state and `btn_valid`.
  - A requester not accepted must hold its data; nothing is dropped silently.
- Legality check on acceptance:
  - A request is illegal if face = 3, or if filter is not one of the five listed codes.
  - An illegal request is acked, discarded, and `req_err` pulses the next cycle. `pending` stays 0.
  - A legal request loads the pending register and sets `pending`.
- State machine, two states:
  - IDLE (`pending=0`) -> HELD on legal accept.
  - HELD -> IDLE on FB.
  - At that FB, `face_select`/`filter_select` load from the pending register, `commit` pulses, and the frame counter clears to 0.
- Frame counter, in IDLE only, on each FB:
  - If `auto_en` and counter = `AUTO_FRAMES-1`: face advances 0→1→2→0, filter is unchanged, `commit` pulses, counter clears.
  - Otherwise the counter increments if `auto_en`, or holds at 0 if `auto_en` is 0.
  - In HELD the counter holds.
- Simultaneous events:
  - Accept and FB in the same cycle while IDLE: the request goes pending and commits at the next FB, not this one. The counter still evaluates this FB as IDLE. If the counter also expires, the auto-advance applies now and the request applies at the next FB.
  - FB while HELD with a requester valid: no accept this cycle, because `pending` was 1 at the start of the cycle. The requester is accepted the following cycle.
  - Commit of the same face/filter as current: `commit` still pulses.
- Reset mid-operation: the pending request is discarded, configuration returns to defaults, and the counter clears.

## Timing
- Reset values: `face_select=0`, `filter_select=0000`, `pending=0`, `commit=0`, `req_err=0`, counter 0. The state is IDLE, so `btn_ready=1` and `aud_ready=~btn_valid` are combinational.
- `face_select`, `filter_select`, `commit`, `pending`, and `req_err` are registered.
- Configuration outputs change in the cycle after the FB cycle, i.e. coincident with the streamer's first pixel index of the next frame.
- Accept-to-`pending` high: 1 cycle.
- Worst-case accept-to-commit: one full frame (640×480 accepted beats) plus 1 cycle.
- There are no combinational paths from `st_*` to any output.

## Test plan
- Reset, then `btn_data`={2'd2,4'b0010} held valid 1 cycle -> `btn_ready`=1, `pending`=1 next cycle. `face_select` stays 0 until the FB, then becomes 2 and `filter_select` becomes 0010 one cycle after the FB, with a 1-cycle `commit`.
- `btn_valid` and `aud_valid` asserted together while IDLE -> button accepted, `aud_ready`=0. After the FB, `aud_ready`=1 and the audio request is accepted.
- `aud_data`={2'd3,4'b0000} -> acked, `req_err` pulse, `pending`=0, outputs unchanged. `aud_data`={0,4'b0011} -> same result.
- `AUTO_FRAMES`=3, `auto_en`=1, no requests, 7 FBs -> face 0→1 after FB3, →2 after FB6, with exactly two `commit` pulses. Repeating to 9 FBs wraps the face to 0.
- Request accepted in the same cycle as an FB -> no commit at that FB, commit at the next FB. Request arriving while HELD with an FB present -> accepted 1 cycle after the FB.
- Assert `reset` while HELD -> next cycle `pending`=0, outputs at defaults, and no commit at a subsequent FB.

Source files
------------

// File: rtl/vga_face_sequencer.sv
// Frame-synchronous owner of the streamer's face/filter configuration: arbitrates two
// requesters, holds one legal request, and commits it (or an auto-advance) on a frame boundary.
module vga_face_sequencer #(
    parameter int AUTO_FRAMES = 60,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       st_valid,
    input  logic       st_ready,
    input  logic       st_endofpacket,
    input  logic       btn_valid,
    input  logic [5:0] btn_data,
    output logic       btn_ready,
    input  logic       aud_valid,
    input  logic [5:0] aud_data,
    output logic       aud_ready,
    input  logic       auto_en,
    output logic [1:0] face_select,
    output logic [3:0] filter_select,
    output logic       pending,
    output logic       commit,
    output logic       req_err
);

    typedef enum logic {IDLE, HELD} state_t;

    state_t           state, state_next;
    logic [5:0]       pend_q, pend_next;
    logic [1:0]       face_next;
    logic [3:0]       filter_next;
    logic             commit_next, err_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic       fb, accept, legal;
    logic [5:0] req;

    assign fb        = st_valid & st_ready & st_endofpacket;
    assign pending   = (state == HELD);
    assign btn_ready = (state == IDLE);
    assign aud_ready = (state == IDLE) & ~btn_valid;
    assign accept    = (btn_valid & btn_ready) | (aud_valid & aud_ready);
    assign req       = btn_valid ? btn_data : aud_data;
    assign legal     = (req[5:4] != 2'd3) && (req[3:0] inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000});

    always_comb begin
        // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latch).
        state_next  = state;
        pend_next   = pend_q;
        face_next   = face_select;
        filter_next = filter_select;
        commit_next = 1'b0;
        err_next    = 1'b0;
        cnt_next    = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_next = HELD;
                        pend_next  = req;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                // A boundary in IDLE is judged on the counter even if a request was just accepted.
                if (fb) begin
                    if (auto_en && cnt == CNT_W'(AUTO_FRAMES - 1)) begin
                        face_next   = (face_select == 2'd2) ? 2'd0 : face_select + 2'd1;
                        commit_next = 1'b1;
                        cnt_next    = '0;
                    end else if (auto_en) begin
                        cnt_next = cnt + CNT_W'(1);
                    end else begin
                        cnt_next = '0;
                    end
                end
            end
            HELD: begin
                if (fb) begin
                    state_next  = IDLE;
                    face_next   = pend_q[5:4];
                    filter_next = pend_q[3:0];
                    commit_next = 1'b1;
                    cnt_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pend_q        <= '0;
            face_select   <= 2'd0;
            filter_select <= 4'b0000;
            commit        <= 1'b0;
            req_err       <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_next;
            pend_q        <= pend_next;
            face_select   <= face_next;
            filter_select <= filter_next;
            commit        <= commit_next;
            req_err       <= err_next;
            cnt           <= cnt_next;
        end
    end

endmodule

// File: tb/tb_vga_face_sequencer.sv
// Self-checking bench for vga_face_sequencer: hand-derived vector table, corner sequences,
// and randomized traffic against a queue-based behavioural model.
module tb_vga_face_sequencer;

    localparam int AUTO = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       st_valid, st_ready, st_endofpacket;
    logic       btn_valid, aud_valid, auto_en;
    logic [5:0] btn_data, aud_data;
    logic       btn_ready, aud_ready;
    logic [1:0] face_select;
    logic [3:0] filter_select;
    logic       pending, commit, req_err;

    vga_face_sequencer #(.AUTO_FRAMES(AUTO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_endofpacket(st_endofpacket),
        .btn_valid(btn_valid), .btn_data(btn_data), .btn_ready(btn_ready),
        .aud_valid(aud_valid), .aud_data(aud_data), .aud_ready(aud_ready),
        .auto_en(auto_en), .face_select(face_select), .filter_select(filter_select),
        .pending(pending), .commit(commit), .req_err(req_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the held request lives in a queue; frames counts boundaries seen while idle.
    logic [5:0] m_q[$];
    int         m_face, m_filter, m_frames;
    bit         m_commit, m_err;

    function automatic bit is_legal(input logic [5:0] d);
        return (d[5:4] < 3) && (d[3:0] == 0 || d[3:0] == 1 || d[3:0] == 2 || d[3:0] == 4 || d[3:0] == 8);
    endfunction

    task automatic model_step(input bit rst, input bit bv, input logic [5:0] bd,
                              input bit av, input logic [5:0] ad, input bit ae, input bit fb);
        bit         took;
        logic [5:0] r;
        m_commit = 0;
        m_err    = 0;
        if (rst) begin
            m_q.delete();
            m_face = 0; m_filter = 0; m_frames = 0;
            return;
        end
        took = (m_q.size() == 0) && (bv || av);
        r    = bv ? bd : ad;
        if (m_q.size() != 0) begin
            if (fb) begin
                r        = m_q.pop_front();
                m_face   = r[5:4];
                m_filter = r[3:0];
                m_commit = 1;
                m_frames = 0;
            end
        end else begin
            if (fb) begin
                if (ae) begin
                    m_frames++;
                    if (m_frames == AUTO) begin
                        m_face   = (m_face + 1) % 3;
                        m_commit = 1;
                        m_frames = 0;
                    end
                end else begin
                    m_frames = 0;
                end
            end
            if (took) begin
                if (is_legal(r)) m_q.push_back(r);
                else m_err = 1;
            end
        end
    endtask

    // One clock: drive inputs, check ready outputs before the edge, then registered outputs after it.
    task automatic cycle(input bit rst, input bit bv, input logic [5:0] bd,
                         input bit av, input logic [5:0] ad, input bit ae, input bit fb);
        int p;
        reset = rst; btn_valid = bv; btn_data = bd; aud_valid = av; aud_data = ad; auto_en = ae;
        if (fb) begin
            st_valid = 1; st_ready = 1; st_endofpacket = 1;
        end else begin
            p = $urandom_range(0, 6);
            {st_valid, st_ready, st_endofpacket} = 3'(p);
        end
        #2;
        check("btn_ready_model", btn_ready, m_q.size() == 0);
        check("aud_ready_model", aud_ready, (m_q.size() == 0) && !bv);
        @(posedge clk);
        model_step(rst, bv, bd, av, ad, ae, fb);
        #1;
        check("face_model",    face_select,   m_face);
        check("filter_model",  filter_select, m_filter);
        check("pending_model", pending,       m_q.size() != 0);
        check("commit_model",  commit,        m_commit);
        check("req_err_model", req_err,       m_err);
    endtask

    typedef struct {
        logic       bv;
        logic [5:0] bd;
        logic       av;
        logic [5:0] ad;
        logic       fb;
        logic       e_brdy, e_ardy;
        logic [1:0] e_face;
        logic [3:0] e_filt;
        logic       e_pend, e_commit, e_err;
    } vec_t;

    vec_t vecs[15];
    int   exp_auto[9];

    initial begin
        int         commits;
        bit         rv_b, rv_a;
        logic [5:0] rd_b, rd_a;
        bit         ae, fb, took_b, took_a;

        vecs[0]  = '{1, 6'b100010, 0, 6'b000000, 0, 1, 0, 2'd0, 4'b0000, 1, 0, 0};
        vecs[1]  = '{0, 6'b000000, 0, 6'b000000, 0, 0, 0, 2'd0, 4'b0000, 1, 0, 0};
        vecs[2]  = '{0, 6'b000000, 0, 6'b000000, 1, 0, 0, 2'd2, 4'b0010, 0, 1, 0};
        vecs[3]  = '{0, 6'b000000, 0, 6'b000000, 0, 1, 1, 2'd2, 4'b0010, 0, 0, 0};
        vecs[4]  = '{1, 6'b010001, 1, 6'b001000, 0, 1, 0, 2'd2, 4'b0010, 1, 0, 0};
        vecs[5]  = '{0, 6'b000000, 1, 6'b001000, 1, 0, 0, 2'd1, 4'b0001, 0, 1, 0};
        vecs[6]  = '{0, 6'b000000, 1, 6'b001000, 0, 1, 1, 2'd1, 4'b0001, 1, 0, 0};
        vecs[7]  = '{0, 6'b000000, 0, 6'b000000, 1, 0, 0, 2'd0, 4'b1000, 0, 1, 0};
        vecs[8]  = '{0, 6'b000000, 1, 6'b110000, 0, 1, 1, 2'd0, 4'b1000, 0, 0, 1};
        vecs[9]  = '{0, 6'b000000, 1, 6'b000011, 0, 1, 1, 2'd0, 4'b1000, 0, 0, 1};
        vecs[10] = '{0, 6'b000000, 0, 6'b000000, 0, 1, 1, 2'd0, 4'b1000, 0, 0, 0};
        vecs[11] = '{1, 6'b000000, 0, 6'b000000, 1, 1, 0, 2'd0, 4'b1000, 1, 0, 0};
        vecs[12] = '{1, 6'b100100, 0, 6'b000000, 1, 0, 0, 2'd0, 4'b0000, 0, 1, 0};
        vecs[13] = '{1, 6'b100100, 0, 6'b000000, 0, 1, 0, 2'd0, 4'b0000, 1, 0, 0};
        vecs[14] = '{0, 6'b000000, 0, 6'b000000, 0, 0, 0, 2'd0, 4'b0000, 1, 0, 0};
        exp_auto = '{0, 0, 1, 1, 1, 2, 2, 2, 0};

        // Reset and idle ready behaviour.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("reset_face",    face_select,   0);
        check("reset_filter",  filter_select, 0);
        check("reset_pending", pending,       0);
        check("reset_commit",  commit,        0);
        check("reset_req_err", req_err,       0);

        // Hand-derived vectors (auto_en off).
        for (int i = 0; i < 15; i++) begin
            reset = 0; btn_valid = vecs[i].bv; btn_data = vecs[i].bd;
            aud_valid = vecs[i].av; aud_data = vecs[i].ad; auto_en = 0;
            #1;
            check($sformatf("vec%0d_btn_ready", i), btn_ready, vecs[i].e_brdy);
            check($sformatf("vec%0d_aud_ready", i), aud_ready, vecs[i].e_ardy);
            cycle(0, vecs[i].bv, vecs[i].bd, vecs[i].av, vecs[i].ad, 0, vecs[i].fb);
            check($sformatf("vec%0d_face", i),    face_select,   vecs[i].e_face);
            check($sformatf("vec%0d_filter", i),  filter_select, vecs[i].e_filt);
            check($sformatf("vec%0d_pending", i), pending,       vecs[i].e_pend);
            check($sformatf("vec%0d_commit", i),  commit,        vecs[i].e_commit);
            check($sformatf("vec%0d_req_err", i), req_err,       vecs[i].e_err);
        end

        // Reset while HELD discards the request; the next boundary commits nothing.
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_held_pending", pending, 0);
        check("rst_held_face",    face_select, 0);
        check("rst_held_filter",  filter_select, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("rst_held_no_commit", commit, 0);
        check("rst_held_filter_fb", filter_select, 0);

        // Auto-cycling, AUTO=3: face advances after boundaries 3, 6 and 9.
        commits = 0;
        for (int k = 0; k < 9; k++) begin
            cycle(0, 0, 0, 0, 0, 1, 1);
            commits += commit;
            check($sformatf("auto_fb%0d_face", k + 1), face_select, exp_auto[k]);
            cycle(0, 0, 0, 0, 0, 1, 0);
            if (k == 6) check("auto_commits_after_7", commits, 2);
        end
        check("auto_commits_after_9", commits, 3);
        check("auto_filter_kept", filter_select, 0);

        // Randomized traffic; requesters hold data until accepted (acceptance judged by the model).
        rv_b = 0; rv_a = 0; rd_b = 0; rd_a = 0;
        for (int n = 0; n < 800; n++) begin
            if (!rv_b && $urandom_range(0, 3) == 0) begin
                rv_b = 1;
                rd_b = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {2'($urandom_range(0, 2)), 4'(1 << $urandom_range(0, 3))};
            end
            if (!rv_a && $urandom_range(0, 2) == 0) begin
                rv_a = 1;
                rd_a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {2'($urandom_range(0, 2)), 4'(1 << $urandom_range(0, 3))};
            end
            ae = ($urandom_range(0, 9) != 0);
            fb = ($urandom_range(0, 3) == 0);
            took_b = (m_q.size() == 0) && rv_b;
            took_a = (m_q.size() == 0) && !rv_b && rv_a;
            if ($urandom_range(0, 199) == 0) begin
                cycle(1, rv_b, rd_b, rv_a, rd_a, ae, fb);
            end else begin
                cycle(0, rv_b, rd_b, rv_a, rd_a, ae, fb);
                if (took_b) rv_b = 0;
                if (took_a) rv_a = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
